// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forwarding selects, load-use stall, multi-cycle EX hold, redirect flush.
// Optional HAZARD_PERF_EN adds saturating stall/flush performance counters.
module hazard_unit #(
  parameter int unsigned AW     = 5,
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CW     = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_uses_rs,
  input  logic          id_uses_rt,
  input  logic          id_wr,
  input  logic [AW-1:0] id_rd,
  input  logic          id_is_load,
  input  logic          id_is_md,
  input  logic          ex_redirect,
  output logic          stall,
  output logic          hold_ex,
  output logic          id_bubble,
  output logic          ex_bubble,
  output logic          flush,
  output logic [1:0]    fwd_rs,
  output logic [1:0]    fwd_rt,
  output logic          md_busy,
  output logic [CW-1:0] stall_count,
  output logic [CW-1:0] flush_count
);

  localparam int unsigned MW = 4;

  // The load flag only matters while the producer sits in EX, so MEM/WB omit it.
  logic          ex_v, ex_ld, ex_us_rs, ex_us_rt;
  logic [AW-1:0] ex_rd, ex_rs, ex_rt;
  logic          mem_v, wb_v;
  logic [AW-1:0] mem_rd, wb_rd;
  logic [MW-1:0] md_cnt;

  logic redirect, load_use;
  logic mem_hit_rs, mem_hit_rt, wb_hit_rs, wb_hit_rt;

  always_comb begin
    md_busy  = (md_cnt != '0);
    redirect = ex_redirect & ~md_busy & reset;
    load_use = id_valid & ex_v & ex_ld & (ex_rd != '0) &
               ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

    stall     = md_busy | (load_use & ~redirect);
    hold_ex   = md_busy;
    ex_bubble = md_busy;
    id_bubble = redirect | load_use;
    flush     = redirect;
  end

  always_comb begin
    mem_hit_rs = mem_v & (mem_rd != '0) & (mem_rd == ex_rs);
    mem_hit_rt = mem_v & (mem_rd != '0) & (mem_rd == ex_rt);
    wb_hit_rs  = wb_v  & (wb_rd  != '0) & (wb_rd  == ex_rs);
    wb_hit_rt  = wb_v  & (wb_rd  != '0) & (wb_rd  == ex_rt);

    fwd_rs = 2'b00;
    if (ex_us_rs && mem_hit_rs)     fwd_rs = 2'b01;
    else if (ex_us_rs && wb_hit_rs) fwd_rs = 2'b10;

    fwd_rt = 2'b00;
    if (ex_us_rt && mem_hit_rt)     fwd_rt = 2'b01;
    else if (ex_us_rt && wb_hit_rt) fwd_rt = 2'b10;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_v     <= 1'b0;
      ex_ld    <= 1'b0;
      ex_us_rs <= 1'b0;
      ex_us_rt <= 1'b0;
      ex_rd    <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      mem_v    <= 1'b0;
      mem_rd   <= '0;
      wb_v     <= 1'b0;
      wb_rd    <= '0;
      md_cnt   <= '0;
    end else begin
      // MEM/WB keep moving while EX is frozen; MEM just receives a bubble.
      wb_v   <= mem_v;
      wb_rd  <= mem_rd;
      mem_v  <= ex_v & ~ex_bubble;
      mem_rd <= ex_rd;
      if (!hold_ex) begin
        ex_v     <= id_valid & id_wr & ~id_bubble;
        ex_ld    <= id_is_load;
        ex_rd    <= id_rd;
        ex_rs    <= id_rs;
        ex_rt    <= id_rt;
        ex_us_rs <= id_uses_rs;
        ex_us_rt <= id_uses_rt;
      end
      if (md_busy)
        md_cnt <= md_cnt - MW'(1);
      else if (id_valid && id_is_md && !id_bubble)
        md_cnt <= MW'(MD_LAT - 1);
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CW-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CW'(1);
      if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + CW'(1);
    end
  end

  assign stall_count = stall_cnt;
  assign flush_count = flush_cnt;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed hazard scenarios plus randomized stimulus
// against a stage-level reference model.
module tb_hazard_unit;
  localparam int AW     = 5;
  localparam int MD_LAT = 4;
  localparam int CW     = 8;
  localparam int CMAX   = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          id_valid, id_uses_rs, id_uses_rt, id_wr, id_is_load, id_is_md, ex_redirect;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic          stall, hold_ex, id_bubble, ex_bubble, flush, md_busy;
  logic [1:0]    fwd_rs, fwd_rt;
  logic [CW-1:0] stall_count, flush_count;

  hazard_unit #(.AW(AW), .MD_LAT(MD_LAT), .CW(CW)) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_wr(id_wr), .id_rd(id_rd), .id_is_load(id_is_load), .id_is_md(id_is_md),
    .ex_redirect(ex_redirect),
    .stall(stall), .hold_ex(hold_ex), .id_bubble(id_bubble), .ex_bubble(ex_bubble),
    .flush(flush), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .md_busy(md_busy),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit v; int rd; bit ld; int rs; int rt; bit urs; bit urt;
  } ent_t;

  ent_t m_ex, m_mem, m_wb;
  int   m_md, m_sc, m_fc;
  int   n_checks = 0;
  int   n_fail   = 0;

  bit s_stall, s_hold, s_idb, s_flush, s_busy;
  int s_frs, s_frt;

  task automatic check(input string tag, input logic [31:0] got, input int expv);
    n_checks++;
    if (got !== 32'(expv)) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
    end
  endtask

  function automatic bit hit(ent_t e, int r);
    return e.v && e.rd != 0 && e.rd == r;
  endfunction

  function automatic int fwd_of(bit use_src, int r);
    if (!use_src) return 0;
    if (hit(m_mem, r)) return 1;
    if (hit(m_wb, r)) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_ex  = '{default: 0};
    m_mem = '{default: 0};
    m_wb  = '{default: 0};
    m_md  = 0;
    m_sc  = 0;
    m_fc  = 0;
  endtask

  // One cycle: apply ID inputs, check every output against the model, then advance the model.
  task automatic step(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                      input bit wr, input int rd, input bit ld, input bit md, input bit redir);
    bit busy, lu, rdr, e_stall, e_idb;
    int e_sc, e_fc;
    @(negedge clock);
    id_valid = v; id_rs = AW'(rs); id_rt = AW'(rt); id_uses_rs = urs; id_uses_rt = urt;
    id_wr = wr; id_rd = AW'(rd); id_is_load = ld; id_is_md = md; ex_redirect = redir;
    #1;
    busy    = m_md > 0;
    lu      = v && m_ex.ld && ((urs && hit(m_ex, rs)) || (urt && hit(m_ex, rt)));
    rdr     = redir && !busy;
    e_idb   = rdr || lu;
    e_stall = busy || (lu && !rdr);
`ifdef HAZARD_PERF_EN
    e_sc = m_sc; e_fc = m_fc;
`else
    e_sc = 0; e_fc = 0;
`endif
    check("stall", stall, e_stall);
    check("hold_ex", hold_ex, busy);
    check("ex_bubble", ex_bubble, busy);
    check("id_bubble", id_bubble, e_idb);
    check("flush", flush, rdr);
    check("md_busy", md_busy, busy);
    check("fwd_rs", fwd_rs, fwd_of(m_ex.urs, m_ex.rs));
    check("fwd_rt", fwd_rt, fwd_of(m_ex.urt, m_ex.rt));
    check("stall_count", stall_count, e_sc);
    check("flush_count", flush_count, e_fc);
    s_stall = stall; s_hold = hold_ex; s_idb = id_bubble; s_flush = flush; s_busy = md_busy;
    s_frs = int'(fwd_rs); s_frt = int'(fwd_rt);
    @(posedge clock);
    m_wb    = m_mem;
    m_mem   = m_ex;
    m_mem.v = m_ex.v && !busy;
    if (!busy) m_ex = '{v: v && wr && !e_idb, rd: rd, ld: ld, rs: rs, rt: rt, urs: urs, urt: urt};
    if (busy) m_md--;
    else if (v && md && !e_idb) m_md = MD_LAT - 1;
    if (e_stall && m_sc < CMAX) m_sc++;
    if (rdr && m_fc < CMAX) m_fc++;
  endtask

  task automatic nop();                  step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic alu(input int rd);      step(1, 1, 2, 1, 1, 1, rd, 0, 0, 0); endtask
  task automatic load(input int rd);     step(1, 1, 0, 1, 0, 1, rd, 1, 0, 0); endtask
  task automatic reader(input int rs);   step(1, rs, 0, 1, 0, 1, 9, 0, 0, 0); endtask
  task automatic mdop(input int rd);     step(1, 1, 2, 1, 1, 1, rd, 0, 1, 0); endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_hold_ex"}, hold_ex, 0);
    check({tag, "_id_bubble"}, id_bubble, 0);
    check({tag, "_ex_bubble"}, ex_bubble, 0);
    check({tag, "_flush"}, flush, 0);
    check({tag, "_md_busy"}, md_busy, 0);
    check({tag, "_fwd_rs"}, fwd_rs, 0);
    check({tag, "_fwd_rt"}, fwd_rt, 0);
    check({tag, "_stall_count"}, stall_count, 0);
    check({tag, "_flush_count"}, flush_count, 0);
  endtask

  initial begin
    int holds;
    reset = 1'b0;
    id_valid = 0; id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0;
    id_wr = 0; id_rd = '0; id_is_load = 0; id_is_md = 0; ex_redirect = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 check_all_zero("rst");
    @(negedge clock) reset = 1'b1;

    // Reset in the middle of a multi-cycle op (md_cnt == 2)
    mdop(7);
    nop();
    @(negedge clock);
    check("md_busy_before_rst", md_busy, 1);
    id_valid = 0; id_is_md = 0; ex_redirect = 0;
    #2 reset = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clock) reset = 1'b1;

    mdop(7);
    holds = 0;
    for (int i = 0; i < 8; i++) begin
      nop();
      if (s_hold) holds++;
    end
    check("md_hold_cycles", holds, MD_LAT - 1);

    // Forwarding: MEM, WB, and MEM priority over WB
    alu(3); reader(3); nop();
    check("fwd_mem", s_frs, 1);
    nop(); nop();
    alu(3); nop(); reader(3); nop();
    check("fwd_wb", s_frs, 2);
    nop(); nop();
    alu(3); alu(3); reader(3); nop();
    check("fwd_mem_over_wb", s_frs, 1);
    nop(); nop();

    // Load-use: one stall, then forward from WB
    load(5); reader(5);
    check("lu_stall", s_stall, 1);
    check("lu_bubble", s_idb, 1);
    reader(5);
    check("lu_stall_once", s_stall, 0);
    nop();
    check("lu_fwd_wb", s_frs, 2);
    nop(); nop();

    // Immediate op naming the load target only in an unused rt field
    load(5); step(1, 1, 5, 1, 0, 1, 6, 0, 0, 0);
    check("imm_no_stall", s_stall, 0);
    nop(); nop();

    // r0 never creates a hazard
    load(0); reader(0);
    check("r0_no_stall", s_stall, 0);
    nop();
    check("r0_no_fwd", s_frs, 0);
    nop(); nop();

    // Multi-cycle op followed by a dependent read
    mdop(7);
    holds = 0;
    for (int i = 0; i < MD_LAT; i++) begin
      reader(7);
      if (s_busy) holds++;
    end
    check("md_busy_cycles", holds, MD_LAT - 1);
    check("md_released", s_hold, 0);
    nop();
    check("md_fwd_mem", s_frs, 1);
    nop(); nop();

    // Redirect beats load-use in the same cycle
    load(5); step(1, 5, 0, 1, 0, 1, 6, 0, 0, 1);
    check("rdr_flush", s_flush, 1);
    check("rdr_bubble", s_idb, 1);
    check("rdr_no_stall", s_stall, 0);
    nop(); nop();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0);
    end

    // Counter saturation
    for (int i = 0; i < 2 * CMAX + 20; i++) begin
      if (i % 2 == 0) load(5);
      else reader(5);
    end
    for (int i = 0; i < CMAX + 10; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    nop();
`ifdef HAZARD_PERF_EN
    check("stall_sat", stall_count, CMAX);
    check("flush_sat", flush_count, CMAX);
`else
    check("stall_tied", stall_count, 0);
    check("flush_tied", flush_count, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
